// File: rtl/instr_sequencer_if.sv
// Handshake and control-bus bundle between the instruction sequencer and the
// 10-bit datapath (register file, ALU A/G registers, shared bus).
interface instr_sequencer_if #(
    parameter int DATA_W = 10
);
    logic              GO;
    logic [DATA_W-1:0] INSTR;
    logic              IRin;
    logic [1:0]        T;
    logic              Ext;
    logic              Rout;
    logic              Gout;
    logic              IMMen;
    logic [DATA_W-1:0] IMM;
    logic [1:0]        RDA;
    logic              Rin;
    logic [1:0]        WRA;
    logic              Ain;
    logic              Gin;
    logic [1:0]        ALUcont;
    logic              done;
    logic              halted;

    modport master (
        output GO, INSTR,
        input  IRin, T, Ext, Rout, Gout, IMMen, IMM, RDA, Rin, WRA,
               Ain, Gin, ALUcont, done, halted
    );

    modport slave (
        input  GO, INSTR,
        output IRin, T, Ext, Rout, Gout, IMMen, IMM, RDA, Rin, WRA,
               Ain, Gin, ALUcont, done, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: latches one instruction per GO in FETCH and walks
// it through up to three execute steps, driving bus selects and enables.
module instr_sequencer #(
    parameter int DATA_W  = 10,
    parameter bit HALT_EN = 1'b1
) (
    input logic              CLK,
    input logic              CLR,
    instr_sequencer_if.slave bus
);
    // T is taken straight from the low state bits; HALT aliases to T=0.
    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S2    = 3'd2;
    localparam logic [2:0] S3    = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_COPY = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_INV  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_INV  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef struct packed {
        logic              irin;
        logic [1:0]        t;
        logic              ext;
        logic              rout;
        logic              gout;
        logic              immen;
        logic [DATA_W-1:0] imm;
        logic [1:0]        rda;
        logic              rin;
        logic [1:0]        wra;
        logic              ain;
        logic              gin;
        logic [1:0]        alu;
        logic              done;
        logic              halted;
    } ctrl_t;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DATA_W-1:0] ir;
    logic [2:0]        op;
    logic [1:0]        rx;
    logic [1:0]        ry;
    logic [1:0]        last_step;
    logic              at_last;
    logic              halt_op;
    ctrl_t             c;

    assign op      = ir[9:7];
    assign rx      = ir[6:5];
    assign ry      = ir[4:3];
    assign halt_op = HALT_EN && (op == OP_HLT);

    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: last_step = 2'd3;
            OP_INV:                  last_step = 2'd2;
            default:                 last_step = 2'd1;
        endcase
    end

    assign at_last = (state != FETCH) && (state != HALT) && (state[1:0] == last_step);

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:      if (bus.GO) state_nxt = S1;
            S1, S2, S3: if (at_last) state_nxt = halt_op ? HALT : FETCH;
                        else         state_nxt = state + 3'd1;
            HALT:       state_nxt = HALT;
            default:    state_nxt = FETCH;
        endcase
    end

    // Outputs decode only from the latched word, so INSTR may change freely mid-instruction.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && bus.GO) ir <= bus.INSTR;
        end
    end

    always_comb begin
        c     = '0;
        c.alu = ALU_PASS;
        case (state)
            FETCH: c.irin   = 1'b1;
            HALT:  c.halted = 1'b1;
            S1, S2, S3: begin
                c.t    = state[1:0];
                c.done = at_last;
                case (op)
                    OP_LOAD: begin
                        c.ext = 1'b1;
                        c.rin = 1'b1;
                        c.wra = rx;
                    end
                    OP_COPY: begin
                        c.rout = 1'b1;
                        c.rda  = ry;
                        c.rin  = 1'b1;
                        c.wra  = rx;
                    end
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        case (state)
                            S1: begin
                                c.rout = 1'b1;
                                c.rda  = rx;
                                c.ain  = 1'b1;
                            end
                            S2: begin
                                if (op == OP_ADDI) begin
                                    c.immen = 1'b1;
                                    c.imm   = {{(DATA_W-5){1'b0}}, ir[4:0]};
                                end else begin
                                    c.rout = 1'b1;
                                    c.rda  = ry;
                                end
                                c.gin = 1'b1;
                                c.alu = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                            end
                            default: begin
                                c.gout = 1'b1;
                                c.rin  = 1'b1;
                                c.wra  = rx;
                            end
                        endcase
                    end
                    OP_INV: begin
                        if (state == S1) begin
                            c.rout = 1'b1;
                            c.rda  = ry;
                            c.gin  = 1'b1;
                            c.alu  = ALU_INV;
                        end else begin
                            c.gout = 1'b1;
                            c.rin  = 1'b1;
                            c.wra  = rx;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.IRin    = c.irin;
    assign bus.T       = c.t;
    assign bus.Ext     = c.ext;
    assign bus.Rout    = c.rout;
    assign bus.Gout    = c.gout;
    assign bus.IMMen   = c.immen;
    assign bus.IMM     = c.imm;
    assign bus.RDA     = c.rda;
    assign bus.Rin     = c.rin;
    assign bus.WRA     = c.wra;
    assign bus.Ain     = c.ain;
    assign bus.Gin     = c.gin;
    assign bus.ALUcont = c.alu;
    assign bus.done    = c.done;
    assign bus.halted  = c.halted;

    a_one_src:  assert property (@(posedge CLK) disable iff (CLR) $onehot0({c.ext, c.rout, c.gout, c.immen}));
    a_rin_gin:  assert property (@(posedge CLK) disable iff (CLR) !(c.rin && c.gin));
    a_done_one: assert property (@(posedge CLK) disable iff (CLR) c.done |=> !c.done);
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench: two sequencers (HALT_EN=1 and 0) share stimulus
// and are compared every cycle against a step-role reference model.
module tb_instr_sequencer;
    typedef struct packed {
        logic       IRin;
        logic [1:0] T;
        logic       Ext;
        logic       Rout;
        logic       Gout;
        logic       IMMen;
        logic [9:0] IMM;
        logic [1:0] RDA;
        logic       Rin;
        logic [1:0] WRA;
        logic       Ain;
        logic       Gin;
        logic [1:0] ALUcont;
        logic       done;
        logic       halted;
    } out_t;

    logic       CLK   = 1'b0;
    logic       CLR   = 1'b1;
    logic       GO    = 1'b0;
    logic [9:0] INSTR = '0;
    bit         mon_en = 1'b0;
    int         errors = 0;
    int         checks = 0;

    // model state, index = HALT_EN of the DUT it tracks
    int         m_k[2];
    logic [9:0] m_ir[2];
    bit         m_halt[2];
    out_t       q0[$];
    out_t       q1[$];
    out_t       act0, act1;

    instr_sequencer_if #(.DATA_W(10)) bus0 ();
    instr_sequencer_if #(.DATA_W(10)) bus1 ();

    assign bus0.GO = GO;
    assign bus0.INSTR = INSTR;
    assign bus1.GO = GO;
    assign bus1.INSTR = INSTR;

    instr_sequencer #(.DATA_W(10), .HALT_EN(1'b0)) u0 (.CLK(CLK), .CLR(CLR), .bus(bus0));
    instr_sequencer #(.DATA_W(10), .HALT_EN(1'b1)) u1 (.CLK(CLK), .CLR(CLR), .bus(bus1));

    assign act0 = {bus0.IRin, bus0.T, bus0.Ext, bus0.Rout, bus0.Gout, bus0.IMMen, bus0.IMM,
                   bus0.RDA, bus0.Rin, bus0.WRA, bus0.Ain, bus0.Gin, bus0.ALUcont,
                   bus0.done, bus0.halted};
    assign act1 = {bus1.IRin, bus1.T, bus1.Ext, bus1.Rout, bus1.Gout, bus1.IMMen, bus1.IMM,
                   bus1.RDA, bus1.Rin, bus1.WRA, bus1.Ain, bus1.Gin, bus1.ALUcont,
                   bus1.done, bus1.halted};

    always #5 CLK = ~CLK;

    function automatic int nsteps(logic [2:0] op);
        case (op)
            3'b010, 3'b011, 3'b110: return 3;
            3'b100:                 return 2;
            default:                return 1;
        endcase
    endfunction

    // Each instruction is: [load A] -> [compute into G] -> writeback on its final step.
    function automatic out_t model_out(int i);
        out_t       o;
        logic [2:0] op;
        int         n;
        int         k;
        o = '0;
        o.ALUcont = 2'b11;
        op = m_ir[i][9:7];
        n = nsteps(op);
        k = m_k[i];
        if (m_halt[i]) begin
            o.halted = 1'b1;
        end else if (k == 0) begin
            o.IRin = 1'b1;
        end else begin
            o.T = 2'(k);
            if (k == n) begin
                o.done = 1'b1;
                if (op != 3'b101 && op != 3'b111) begin
                    o.Rin = 1'b1;
                    o.WRA = m_ir[i][6:5];
                    if (op == 3'b000) o.Ext = 1'b1;
                    else if (op == 3'b001) begin
                        o.Rout = 1'b1;
                        o.RDA  = m_ir[i][4:3];
                    end else o.Gout = 1'b1;
                end
            end else if (k == n - 1) begin
                o.Gin = 1'b1;
                if (op == 3'b110) begin
                    o.IMMen   = 1'b1;
                    o.IMM     = 10'(m_ir[i][4:0]);
                    o.ALUcont = 2'b00;
                end else begin
                    o.Rout    = 1'b1;
                    o.RDA     = m_ir[i][4:3];
                    o.ALUcont = (op == 3'b100) ? 2'b10 : (op == 3'b011) ? 2'b01 : 2'b00;
                end
            end else begin
                o.Rout = 1'b1;
                o.RDA  = m_ir[i][6:5];
                o.Ain  = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic void model_reset(int i);
        m_k[i]    = 0;
        m_ir[i]   = '0;
        m_halt[i] = 1'b0;
    endfunction

    function automatic void model_step(int i, bit g, logic [9:0] ins);
        if (m_halt[i]) return;
        if (m_k[i] == 0) begin
            if (g) begin
                m_ir[i] = ins;
                m_k[i]  = 1;
            end
        end else if (m_k[i] == nsteps(m_ir[i][9:7])) begin
            m_k[i] = 0;
            if (m_ir[i][9:7] == 3'b111 && i == 1) m_halt[i] = 1'b1;
        end else begin
            m_k[i] = m_k[i] + 1;
        end
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rise.
    task automatic cycle(input bit g, input logic [9:0] ins, input bit c);
        @(negedge CLK);
        mon_en = 1'b1;
        GO     = g;
        INSTR  = ins;
        if (c && !CLR) begin
            model_reset(0);
            model_reset(1);
            q0.push_back(model_out(0));
            q1.push_back(model_out(1));
            CLR = 1'b1;
        end else if (!c) begin
            CLR = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (c) model_reset(i);
            else   model_step(i, g, ins);
        end
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    initial begin : monitor
        out_t a;
        out_t e;
        bit   empty;
        wait (mon_en);
        forever begin
            @(posedge CLK or posedge CLR);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                a = (i == 0) ? act0 : act1;
                if (empty) begin
                    errors++;
                    $display("FAIL dut%0d scoreboard_underflow @%0t got %h required <queued entry>", i, $time, a);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL dut%0d ctrl_word @%0t got %h required %h (T %0d/%0d done %0d/%0d)",
                                 i, $time, a, e, a.T, e.T, a.done, e.done);
                    end
                end
            end
        end
    end

    localparam logic [9:0] I_LOAD_R2  = 10'b000_10_00000;
    localparam logic [9:0] I_ADD_R1R2 = 10'b010_01_10_000;
    localparam logic [9:0] I_ADD_R1R1 = 10'b010_01_01_000;
    localparam logic [9:0] I_ADDI     = 10'b110_11_10101;
    localparam logic [9:0] I_SUB      = 10'b011_00_11_000;
    localparam logic [9:0] I_INV      = 10'b100_10_01_000;
    localparam logic [9:0] I_COPY     = 10'b001_11_01_000;
    localparam logic [9:0] I_HLT      = 10'b111_0000000;

    initial begin : stimulus
        model_reset(0);
        model_reset(1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, I_ADD_R1R2, 1'b1);
        // LOAD, then back-to-back ADD / ADDI with GO held high
        cycle(1'b1, I_LOAD_R2, 1'b0);
        cycle(1'b0, '0, 1'b0);
        repeat (4) cycle(1'b1, I_ADD_R1R2, 1'b0);
        repeat (4) cycle(1'b1, I_ADDI, 1'b0);
        repeat (4) cycle(1'b1, I_ADD_R1R1, 1'b0);
        cycle(1'b0, '0, 1'b0);
        // SUB with INSTR scrambled and GO pulsing mid-instruction
        cycle(1'b1, I_SUB, 1'b0);
        cycle(1'b1, 10'h3FF, 1'b0);
        cycle(1'b0, 10'h155, 1'b0);
        cycle(1'b1, 10'h2AA, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, I_INV, 1'b0);
        cycle(1'b1, I_COPY, 1'b0);
        cycle(1'b0, '0, 1'b0);
        // CLR asserted while ADD sits in S2
        cycle(1'b1, I_ADD_R1R2, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        // opcode 111: halts one DUT, single-step NOP in the other
        cycle(1'b1, I_HLT, 1'b0);
        repeat (20) cycle(1'b1, I_ADD_R1R2, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, I_LOAD_R2, 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(99) < 70, 10'($urandom), $urandom_range(39) == 0);
        end
        cycle(1'b0, '0, 1'b0);
        @(posedge CLK);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
